fifo_dispatch: RTL and testbench
================================

Name: fifo_dispatch

Overview:
- Read-side consumer of the input FIFO. Pops words and decodes the 2-bit destination field (top two data bits). Forwards each word to one of four downstream FIFOs, honouring each downstream almost-full flag.
- Holds the threshold-programming FSM (RESET/INIT/IDLE/ACTIVE). Provides the limit values to all FIFOs.
- Keeps per-destination packet counters for the verification bench.

Parameters:
- DATA_BITS, 10, word width; destination = data[DATA_BITS-1:DATA_BITS-2]
- ADDR_BITS, 3, FIFO address width; sets the width of the limit values
- CNT_BITS, 5, width of each per-destination packet counter

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-low
- init  input  1  request threshold programming
- high_limit_in  input  ADDR_BITS  almost-full threshold, latched in INIT
- low_limit_in  input  ADDR_BITS  almost-empty threshold, latched in INIT
- in_empty  input  1  input FIFO empty/almost-empty flag
- in_data  input  DATA_BITS  input FIFO read data, valid the cycle after pop
- pop  output  1  input FIFO read strobe
- out_full  input  4  downstream almost-full flags, bit i = destination i
- push  output  4  downstream write strobes, one-hot or zero
- data_out  output  DATA_BITS  word driven to all downstream FIFOs
- high_limit  output  ADDR_BITS  programmed almost-full threshold
- low_limit  output  ADDR_BITS  programmed almost-empty threshold
- state_out  output  2  0=RESET 1=INIT 2=IDLE 3=ACTIVE
- idle_out  output  1  high in IDLE only
- cnt_sel  input  2  counter select
- cnt_out  output  CNT_BITS  selected counter value, combinational mux

Behaviour:
- Reset (reset=0 at posedge):
  - state returns to RESET; high_limit and low_limit clear to 0.
  - hold_valid, pend and all counters clear to 0; any word in flight is discarded.
  - pop=0, push=0, data_out=0, idle_out=0.
- FSM transitions:
  - RESET -> INIT unconditionally on the first clock with reset=1.
  - INIT: latch high_limit_in and low_limit_in every cycle. Go to IDLE when init=0.
  - IDLE -> ACTIVE when in_empty=0.
  - ACTIVE -> IDLE when in_empty=1, pend=0 and hold_valid=0.
  - init=1 in IDLE or ACTIVE -> INIT on the next clock.
- Pop rule:
  - pop = (state==ACTIVE) & !in_empty & !pend & (!hold_valid | drain).
  - pop is combinational.
  - pend is a register holding pop from the previous cycle.
  - pend blocks a second pop while the input FIFO's empty flag is still one cycle stale.
- Capture:
  - When pend=1, in_data is registered into the hold register at the posedge.
  - hold_valid is set and hold_dest = in_data[DATA_BITS-1:DATA_BITS-2].
- Drain:
  - drain = hold_valid & !out_full[hold_dest].
  - push[hold_dest] = drain; every other push bit is 0.
  - data_out = hold register whenever hold_valid=1, otherwise it keeps its last value.
  - hold_valid clears on drain unless a capture happens in the same cycle; capture wins and the hold register reloads.
- Latency and throughput:
  - pop at cycle t -> push at cycle t+2 at the earliest.
  - Sustained rate is 1 word per 2 cycles.
- Stall:
  - While out_full[hold_dest]=1, the word stays in hold; push=0 and pop=0.
  - No word is ever dropped or duplicated.
- Entry into INIT:
  - pop is suppressed.
  - A pending capture completes and the hold register still drains normally.
- Counters:
  - counter[hold_dest] increments on each drain.
  - Counters wrap from 2^CNT_BITS-1 to 0.
  - Counters are not cleared by INIT.

Test Plan:
- Reset then init=1 with high=6, low=1, then init=0 -> state_out goes 0,1,2; high_limit=6, low_limit=1; pop=0 and push=0 throughout.
- Input FIFO holds 0x2A5 (dest 2), out_full=0 -> pop for 1 cycle; two cycles later push=4'b0100 and data_out=0x2A5; counter 2 = 1; state returns to IDLE once the FIFO is empty.
- Input FIFO holds dest 1 then dest 1, out_full[1]=1 for 5 cycles -> first word held with push=0 and pop=0 for 5 cycles; then both words pushed in order; counter 1 = 2.
- Stream 8 words cycling dests 0..3 with out_full=0 -> pushes spaced 2 cycles apart in order 0,1,2,3,0,1,2,3; every counter = 2.
- Assert reset while hold_valid=1 -> next cycle push=0, all counters=0, state=RESET.
- 32 drains to dest 3 with CNT_BITS=5 -> cnt_out (cnt_sel=3) wraps to 0.

Source files
------------

// File: rtl/fifo_dispatch.sv
// Input-FIFO consumer: pops words, steers each to one of four downstream FIFOs by
// its top two bits, owns the limit-programming FSM and per-destination counters.
module fifo_dispatch #(
  parameter int DATA_BITS = 10,
  parameter int ADDR_BITS = 3,
  parameter int CNT_BITS  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [ADDR_BITS-1:0] high_limit_in,
  input  logic [ADDR_BITS-1:0] low_limit_in,
  input  logic                 in_empty,
  input  logic [DATA_BITS-1:0] in_data,
  output logic                 pop,
  input  logic [3:0]           out_full,
  output logic [3:0]           push,
  output logic [DATA_BITS-1:0] data_out,
  output logic [ADDR_BITS-1:0] high_limit,
  output logic [ADDR_BITS-1:0] low_limit,
  output logic [1:0]           state_out,
  output logic                 idle_out,
  input  logic [1:0]           cnt_sel,
  output logic [CNT_BITS-1:0]  cnt_out
);

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_e;

  state_e               state_q;
  logic [ADDR_BITS-1:0] high_q, low_q;
  logic                 pend_q;
  logic                 hold_valid_q, hold_valid_d;
  logic [DATA_BITS-1:0] hold_q;
  logic [1:0]           hold_dest;
  logic                 drain;
  logic [CNT_BITS-1:0]  cnt_q [4];

  assign hold_dest = hold_q[DATA_BITS-1 -: 2];
  assign drain     = hold_valid_q & ~out_full[hold_dest];

  // pend_q covers the cycle where the popped word is on in_data but in_empty may be stale.
  assign pop = (state_q == ST_ACTIVE) & ~in_empty & ~pend_q & (~hold_valid_q | drain);

  // NOTE: every signal written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    push            = 4'b0000;
    push[hold_dest] = drain;
  end

  // A capture in the same cycle as a drain wins: the hold register reloads and stays valid.
  always_comb begin
    hold_valid_d = hold_valid_q;
    if (pend_q)     hold_valid_d = 1'b1;
    else if (drain) hold_valid_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RESET;
      high_q  <= '0;
      low_q   <= '0;
    end else begin
      case (state_q)
        ST_RESET: state_q <= ST_INIT;
        ST_INIT: begin
          high_q <= high_limit_in;
          low_q  <= low_limit_in;
          if (!init) state_q <= ST_IDLE;
        end
        ST_IDLE: begin
          if (init)           state_q <= ST_INIT;
          else if (!in_empty) state_q <= ST_ACTIVE;
        end
        ST_ACTIVE: begin
          if (init)                                     state_q <= ST_INIT;
          else if (in_empty && !pend_q && !hold_valid_q) state_q <= ST_IDLE;
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  // NOTE: the hold register and counters are cleared on reset because data_out and cnt_out are visible.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend_q       <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      pend_q       <= pop;
      hold_valid_q <= hold_valid_d;
      if (pend_q) hold_q <= in_data;
      if (drain)  cnt_q[hold_dest] <= cnt_q[hold_dest] + CNT_BITS'(1);
    end
  end

  assign data_out   = hold_q;
  assign high_limit = high_q;
  assign low_limit  = low_q;
  assign state_out  = state_q;
  assign idle_out   = (state_q == ST_IDLE);
  assign cnt_out    = cnt_q[cnt_sel];

endmodule

// File: tb/tb_fifo_dispatch.sv
// Self-checking bench for fifo_dispatch: queue-based input FIFO and in-order scoreboard,
// directed scenarios plus a randomized stall/stream run.
module tb_fifo_dispatch;
  localparam int DB = 10;
  localparam int AB = 3;
  localparam int CB = 5;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          init = 1'b0;
  logic [AB-1:0] high_limit_in = '0;
  logic [AB-1:0] low_limit_in = '0;
  logic          in_empty = 1'b1;
  logic [DB-1:0] in_data = '0;
  logic          pop;
  logic [3:0]    out_full = 4'b0000;
  logic [3:0]    push;
  logic [DB-1:0] data_out;
  logic [AB-1:0] high_limit, low_limit;
  logic [1:0]    state_out;
  logic          idle_out;
  logic [1:0]    cnt_sel = 2'd0;
  logic [CB-1:0] cnt_out;

  fifo_dispatch #(.DATA_BITS(DB), .ADDR_BITS(AB), .CNT_BITS(CB)) dut (
    .clk(clk), .reset(reset), .init(init),
    .high_limit_in(high_limit_in), .low_limit_in(low_limit_in),
    .in_empty(in_empty), .in_data(in_data), .pop(pop),
    .out_full(out_full), .push(push), .data_out(data_out),
    .high_limit(high_limit), .low_limit(low_limit),
    .state_out(state_out), .idle_out(idle_out),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DB-1:0] fifo_q[$];
  logic [DB-1:0] exp_q[$];
  int            pop_cyc_q[$];
  int            push_cyc_q[$];
  int            cyc = 0;
  int            pop_cnt = 0;
  int            push_cnt = 0;
  int            last_lat = 0;
  logic [3:0]    last_push = 4'b0000;
  logic [DB-1:0] last_data = '0;
  int            cnt_m[4] = '{0, 0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic load(input logic [DB-1:0] w);
    fifo_q.push_back(w);
    in_empty = 1'b0;
  endtask

  // One clock: watch outputs mid-cycle, then model the input FIFO's response to pop.
  task automatic tick();
    logic [DB-1:0] w;
    logic          popped;
    @(negedge clk);
    cyc++;
    if (push != 4'b0000) begin
      push_cnt++;
      push_cyc_q.push_back(cyc);
      last_push = push;
      last_data = data_out;
      check("push_onehot", $countones(push), 1);
      check("push_not_full", {28'd0, out_full & push}, 0);
      check("sb_has_word", {31'd0, exp_q.size() > 0}, 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        last_lat = cyc - pop_cyc_q.pop_front();
        check("push_data", {22'd0, data_out}, {22'd0, w});
        check("push_dest", {28'd0, push}, {28'd0, 4'b0001 << w[DB-1:DB-2]});
        check("push_latency_min", {31'd0, last_lat >= 2}, 1);
        cnt_m[w[DB-1:DB-2]]++;
      end
    end
    popped = pop;
    if (pop) begin
      pop_cnt++;
      check("pop_nonempty", {31'd0, in_empty}, 0);
      check("pop_single_buffer", exp_q.size(), 0);
    end
    @(posedge clk);
    #1;
    if (popped && fifo_q.size() > 0) begin
      w = fifo_q.pop_front();
      in_data = w;
      exp_q.push_back(w);
      pop_cyc_q.push_back(cyc);
    end
    in_empty = (fifo_q.size() == 0);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!(state_out == 2'd2 && fifo_q.size() == 0 && exp_q.size() == 0) && n < budget);
    check("reach_idle", {30'd0, state_out}, 2);
    check("sb_drained", exp_q.size(), 0);
  endtask

  task automatic check_counters(input string tag);
    for (int i = 0; i < 4; i++) begin
      cnt_sel = 2'(i);
      #1;
      check($sformatf("%s_cnt%0d", tag, i), {27'd0, cnt_out}, cnt_m[i] % 32);
    end
  endtask

  initial begin
    int base_push, base_pop, n_loaded;
    logic [DB-1:0] w;

    // Reset and limit programming
    tick();
    tick();
    check("rst_state", {30'd0, state_out}, 0);
    check("rst_high", {29'd0, high_limit}, 0);
    check("rst_low", {29'd0, low_limit}, 0);
    check("rst_idle", {31'd0, idle_out}, 0);
    check("rst_data", {22'd0, data_out}, 0);
    reset = 1'b1; init = 1'b1; high_limit_in = 3'd6; low_limit_in = 3'd1;
    tick();
    check("st_init", {30'd0, state_out}, 1);
    tick();
    init = 1'b0;
    tick();
    check("st_idle", {30'd0, state_out}, 2);
    check("idle_out", {31'd0, idle_out}, 1);
    check("high_limit", {29'd0, high_limit}, 6);
    check("low_limit", {29'd0, low_limit}, 1);
    check("init_no_pop", pop_cnt, 0);
    check("init_no_push", push_cnt, 0);

    // Single word to destination 2
    load(10'h2A5);
    wait_idle(20);
    check("single_push_cnt", push_cnt, 1);
    check("single_pop_cnt", pop_cnt, 1);
    check("single_push_vec", {28'd0, last_push}, 4'b0100);
    check("single_data", {22'd0, last_data}, 10'h2A5);
    check("single_latency", last_lat, 2);
    check_counters("single");

    // Two words to destination 1 with a five-cycle stall
    out_full = 4'b0010;
    load(10'h155);
    load(10'h1AA);
    tick(); tick(); tick();
    base_push = push_cnt;
    base_pop = pop_cnt;
    repeat (5) tick();
    check("stall_no_push", push_cnt - base_push, 0);
    check("stall_no_pop", pop_cnt - base_pop, 0);
    out_full = 4'b0000;
    wait_idle(30);
    check("stall_total_push", push_cnt - base_push, 2);
    check_counters("stall");

    // Back-to-back stream cycling destinations
    push_cyc_q.delete();
    base_push = push_cnt;
    for (int i = 0; i < 8; i++) load({2'(i % 4), 8'($urandom)});
    wait_idle(60);
    check("stream_push_cnt", push_cnt - base_push, 8);
    for (int i = 1; i < push_cyc_q.size(); i++)
      check($sformatf("stream_gap%0d", i), push_cyc_q[i] - push_cyc_q[i-1], 2);
    check_counters("stream");

    // Randomized traffic with random downstream back-pressure
    base_push = push_cnt;
    n_loaded = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        w = DB'($urandom);
        load(w);
        n_loaded++;
      end
      out_full = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      tick();
    end
    out_full = 4'b0000;
    wait_idle(500);
    check("rand_push_cnt", push_cnt - base_push, n_loaded);
    check_counters("rand");

    // Entering INIT with a capture pending: the word must still be delivered
    base_push = push_cnt;
    load(10'h0F3);
    tick();
    tick();
    init = 1'b1;
    tick();
    check("init_entry_state", {30'd0, state_out}, 1);
    init = 1'b0;
    wait_idle(20);
    check("init_entry_push", push_cnt - base_push, 1);

    // Reset while a word is held
    out_full = 4'b1111;
    load(10'h3C1);
    tick(); tick(); tick();
    reset = 1'b0;
    tick();
    check("rst2_state", {30'd0, state_out}, 0);
    check("rst2_push", {28'd0, push}, 0);
    check("rst2_data", {22'd0, data_out}, 0);
    exp_q.delete();
    pop_cyc_q.delete();
    fifo_q.delete();
    in_empty = 1'b1;
    for (int i = 0; i < 4; i++) cnt_m[i] = 0;
    check_counters("rst2");
    out_full = 4'b0000;
    reset = 1'b1;
    init = 1'b1;
    tick();
    init = 1'b0;
    tick();
    check("rst2_idle", {30'd0, state_out}, 2);

    // 32 drains to destination 3 wrap its counter
    base_push = push_cnt;
    for (int i = 0; i < 32; i++) load({2'd3, 8'($urandom)});
    wait_idle(200);
    check("wrap_push_cnt", push_cnt - base_push, 32);
    cnt_sel = 2'd3;
    #1;
    check("wrap_cnt3_zero", {27'd0, cnt_out}, 0);
    check_counters("wrap");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
